nios_upc_nios2_qsys_0_ocimem_arbiter: RTL and testbench
=======================================================

Name: nios_upc_nios2_qsys_0_ocimem_arbiter

Overview:
- Shares the single-port on-chip debug RAM (OCIMEM, 256x32) between two requesters: the JTAG debug command path (jdo, take_action_ocimem_*, take_no_action_ocimem_a from the debug-module sysclk side) and the CPU's Avalon debug slave.
- Captures the single-cycle JTAG strobes into a pending request and arbitrates against Avalon traffic.
- Sequences the RAM access. Owns MonAReg/MonDReg and monitor_ready.

Parameters:
- ADDR_W, 8, OCIMEM word-address width.
- DATA_W, 32, data width (byte enables = DATA_W/8).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- jdo  in  38  JTAG data out, sampled only on take_* strobes
- take_action_ocimem_a  in  1  load MonAReg; optionally read
- take_action_ocimem_b  in  1  write MonDReg to MonAReg, then increment
- take_no_action_ocimem_a  in  1  read at MonAReg, then increment
- av_address  in  ADDR_W  Avalon word address
- av_read  in  1  Avalon read
- av_write  in  1  Avalon write
- av_writedata  in  DATA_W  Avalon write data
- av_byteenable  in  DATA_W/8  Avalon byte enables
- av_waitrequest  out  1  Avalon stall
- av_readdata  out  DATA_W  Avalon read data
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_be  out  DATA_W/8  RAM byte enables
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, registered, 1-cycle latency
- MonAReg  out  ADDR_W  JTAG address register
- MonDReg  out  DATA_W  JTAG data register
- monitor_ready  out  1  no JTAG access pending or in flight
- jtag_overrun  out  1  sticky: JTAG strobe arrived while one was pending

Behaviour:
- Reset (async, reset_n low): all outputs are 0, except av_waitrequest and monitor_ready, which are 1. State is IDLE, pending is cleared, last_grant=AV. An access in flight is abandoned and RAM outputs go low immediately.
- JTAG capture (registered):
  - ocimem_a: MonAReg<=jdo[ADDR_W+25:26]. If jdo[34]=1, post pending READ.
  - ocimem_b: MonDReg<=jdo[34:3]; post pending WRITE.
  - no_action_ocimem_a: post pending READ.
  - Only one pending slot exists. A strobe while pending or in flight sets jtag_overrun and is ignored; its MonAReg/MonDReg load is also ignored.
  - jtag_overrun clears on the next accepted ocimem_a.
  - monitor_ready = !pending && state==IDLE && !jtag_owner.
- Avalon request = av_read|av_write. av_waitrequest=1 whenever a request is present and not in its completion cycle. av_read and av_write are never both asserted; if they are, write wins.
- FSM states: IDLE, ACC, RDAT.
  - IDLE: with both requesters asking, grant goes to !last_grant (round robin); otherwise grant goes to whichever asks. The grant is registered into owner and last_grant, then the FSM moves to ACC. No request: stay in IDLE.
  - ACC: drive ram_addr (AV: av_address; JTAG: MonAReg).
    - Write: ram_we=1. be = av_byteenable for AV, or all ones for JTAG. wdata = av_writedata or MonDReg. On AV, av_waitrequest=0 this cycle. On JTAG, MonAReg increments (wraps 0xFF->0x00) and pending clears. Next state IDLE.
    - Read: next state RDAT.
  - RDAT: AV: av_readdata=ram_rdata, av_waitrequest=0. JTAG: MonDReg<=ram_rdata, MonAReg++ (wrap), pending clears. Next state IDLE.
- Latency from IDLE with no contention: write completes in 2 cycles, read in 3 cycles. Back-to-back accesses insert one IDLE cycle.
- Avalon address/data are held stable by the master while waitrequest=1. These inputs are sampled in ACC, not in IDLE.
- JTAG reads after ocimem_a with jdo[34]=1 use the newly loaded MonAReg.

Optional Feature:
- Macro NIOS_UPC_OCIMEM_JTAG_PRIO_EN.
- Defined: strict JTAG priority in IDLE. last_grant is unused; Avalon is starved while a JTAG request is pending.
- Undefined: round robin as described in Behaviour.

Decomposition:
- Package nios_upc_ocimem_pkg holds:
  - state enum (IDLE/ACC/RDAT);
  - owner enum (AV/JTAG);
  - the jdo field-position constants (ADDR_LSB=26, DATA_LSB=3, RDREQ_BIT=34);
  - OCIMEM_DEPTH=256.
- One sub-module, nios_upc_ocimem_jtag_capture: the strobe decode, pending slot, overrun flag and MonAReg/MonDReg update. It is handed complete/readdata by the FSM.

Test Plan:
- Reset mid-read: assert reset_n=0 during RDAT -> next edge state=IDLE, av_waitrequest=1, ram_we=0, monitor_ready=1, MonAReg=0.
- JTAG write: ocimem_a with jdo[33:26]=0x10, jdo[34]=0, then ocimem_b with data 0xDEADBEEF -> ram_we=1 at addr 0x10 with be=0xF, MonAReg=0x11, monitor_ready returns to 1.
- JTAG read with wrap: RAM[0xFF]=0x12345678; ocimem_a with addr 0xFF, jdo[34]=1 -> MonDReg=0x12345678 two cycles after the access starts, MonAReg=0x00.
- Avalon read/write: write 0xA5A5A5A5 to addr 3 with be=0x3 -> waitrequest low in cycle 2, only low halfword written; read addr 3 -> readdata valid in cycle 3.
- Contention: Avalon read and JTAG pending in the same IDLE with last_grant=JTAG -> AV served first, JTAG next. Repeat with NIOS_UPC_OCIMEM_JTAG_PRIO_EN defined -> JTAG served first.
- Overrun: second no_action_ocimem_a while the first is pending -> jtag_overrun=1, only one RAM read issued, MonAReg incremented once; next ocimem_a clears the flag.

Source files
------------

// File: rtl/nios_upc_ocimem_pkg.sv
// Shared types and constants for the OCIMEM arbiter.
// Build option: NIOS_UPC_OCIMEM_JTAG_PRIO_EN selects strict JTAG priority
// instead of round robin (used by the top module only).
package nios_upc_ocimem_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StRdat = 2'd2
  } state_e;

  // Requester that owns the current RAM access
  typedef enum logic {
    OwnAv   = 1'b0,
    OwnJtag = 1'b1
  } owner_e;

  // jdo field positions
  localparam int unsigned JDO_W     = 38;
  localparam int unsigned ADDR_LSB  = 26;
  localparam int unsigned DATA_LSB  = 3;
  localparam int unsigned RDREQ_BIT = 34;

  localparam int unsigned OCIMEM_DEPTH = 256;

  // Round-robin choice when both requesters ask in the same cycle
  function automatic owner_e rr_pick(input owner_e last);
    return (last == OwnAv) ? OwnJtag : OwnAv;
  endfunction

endpackage

// File: rtl/nios_upc_ocimem_jtag_capture.sv
// JTAG side of the OCIMEM arbiter: turns single-cycle take_* strobes into one
// pending request, owns MonAReg/MonDReg and the sticky overrun flag.
module nios_upc_ocimem_jtag_capture
  import nios_upc_ocimem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [JDO_W-1:0]  i_jdo,
  input  logic              i_take_a,
  input  logic              i_take_b,
  input  logic              i_take_noact,
  // Pulsed by the sequencer in the completion cycle of a JTAG access
  input  logic              i_complete,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_pending,
  output logic              o_pend_wr,
  output logic [ADDR_W-1:0] o_mon_addr,
  output logic [DATA_W-1:0] o_mon_data,
  output logic              o_overrun
);

  logic              r_pending;
  logic              r_pend_wr;
  logic [ADDR_W-1:0] r_mon_addr;
  logic [DATA_W-1:0] r_mon_data;
  logic              r_overrun;

  logic w_any_strobe;
  logic w_accept;
  logic w_unused_jdo;

  assign w_any_strobe = i_take_a | i_take_b | i_take_noact;
  // The slot stays occupied until the access completes, so it also covers
  // the in-flight phase.
  assign w_accept     = w_any_strobe & ~r_pending;

  // jdo bits outside the address/data/read-request fields carry nothing here
  assign w_unused_jdo = ^{i_jdo[JDO_W-1:RDREQ_BIT+1], i_jdo[DATA_LSB-1:0]};

  // Overrun flag: set on a rejected strobe, cleared by an accepted ocimem_a
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_overrun <= 1'b0;
    end else if (w_any_strobe && r_pending) begin
      r_overrun <= 1'b1;
    end else if (i_take_a) begin
      r_overrun <= 1'b0;
    end
  end

  // Pending slot and monitor registers; accept and complete are exclusive
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pending  <= 1'b0;
      r_pend_wr  <= 1'b0;
      r_mon_addr <= '0;
      r_mon_data <= '0;
    end else if (w_accept) begin
      if (i_take_a) begin
        r_mon_addr <= i_jdo[ADDR_LSB +: ADDR_W];
        if (i_jdo[RDREQ_BIT]) begin
          r_pending <= 1'b1;
          r_pend_wr <= 1'b0;
        end
      end else if (i_take_b) begin
        r_mon_data <= i_jdo[DATA_LSB +: DATA_W];
        r_pending  <= 1'b1;
        r_pend_wr  <= 1'b1;
      end else begin
        r_pending  <= 1'b1;
        r_pend_wr  <= 1'b0;
      end
    end else if (i_complete) begin
      r_pending  <= 1'b0;
      // Address wraps naturally at the RAM depth
      r_mon_addr <= r_mon_addr + ADDR_W'(1);
      if (!r_pend_wr) begin
        r_mon_data <= i_rdata;
      end
    end
  end

  assign o_pending  = r_pending;
  assign o_pend_wr  = r_pend_wr;
  assign o_mon_addr = r_mon_addr;
  assign o_mon_data = r_mon_data;
  assign o_overrun  = r_overrun;

endmodule

// File: rtl/nios_upc_nios2_qsys_0_ocimem_arbiter.sv
// Arbitrates the single-port OCIMEM (256x32) between the JTAG debug path and
// the CPU's Avalon debug slave, and sequences each RAM access.
// Build option: NIOS_UPC_OCIMEM_JTAG_PRIO_EN -- strict JTAG priority in IDLE
// (Avalon starves while JTAG is pending); otherwise round robin.
module nios_upc_nios2_qsys_0_ocimem_arbiter
  import nios_upc_ocimem_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [JDO_W-1:0]      jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic                  take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0]     av_address,
  input  logic                  av_read,
  input  logic                  av_write,
  input  logic [DATA_W-1:0]     av_writedata,
  input  logic [DATA_W/8-1:0]   av_byteenable,
  output logic                  av_waitrequest,
  output logic [DATA_W-1:0]     av_readdata,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [DATA_W/8-1:0]   ram_be,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic [ADDR_W-1:0]     MonAReg,
  output logic [DATA_W-1:0]     MonDReg,
  output logic                  monitor_ready,
  output logic                  jtag_overrun
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_e r_state;
  state_e w_state_nxt;
  owner_e r_owner;
  owner_e w_grant;
  logic   w_grant_ld;

  logic w_av_req;
  logic w_jtag_req;
  logic w_pend_wr;
  logic w_jtag_done;
  logic w_acc_wr;
  logic w_jtag_owner;

  assign w_av_req = av_read | av_write;

  nios_upc_ocimem_jtag_capture #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_jtag_capture (
    .i_clk        (clk),
    .i_reset_n    (reset_n),
    .i_jdo        (jdo),
    .i_take_a     (take_action_ocimem_a),
    .i_take_b     (take_action_ocimem_b),
    .i_take_noact (take_no_action_ocimem_a),
    .i_complete   (w_jtag_done),
    .i_rdata      (ram_rdata),
    .o_pending    (w_jtag_req),
    .o_pend_wr    (w_pend_wr),
    .o_mon_addr   (MonAReg),
    .o_mon_data   (MonDReg),
    .o_overrun    (jtag_overrun)
  );

`ifdef NIOS_UPC_OCIMEM_JTAG_PRIO_EN
  // Grant selection: JTAG always wins when pending
  always_comb begin
    w_grant = OwnAv;
    if (w_jtag_req) begin
      w_grant = OwnJtag;
    end
  end
`else
  owner_e r_last_grant;

  // Grant selection: alternate when both ask, otherwise the sole requester
  always_comb begin
    w_grant = OwnAv;
    if (w_jtag_req && w_av_req) begin
      w_grant = rr_pick(r_last_grant);
    end else if (w_jtag_req) begin
      w_grant = OwnJtag;
    end
  end

  // Remember the most recent grant for round robin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= OwnAv;
    end else if (w_grant_ld) begin
      r_last_grant <= w_grant;
    end
  end
`endif

  // State and owner registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_owner <= OwnAv;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_ld) begin
        r_owner <= w_grant;
      end
    end
  end

  // Next state and RAM/Avalon outputs; RAM is driven only in ACC
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_ld     = 1'b0;
    w_jtag_done    = 1'b0;
    w_acc_wr       = 1'b0;
    ram_addr       = '0;
    ram_we         = 1'b0;
    ram_be         = '0;
    ram_wdata      = '0;
    av_waitrequest = 1'b1;
    av_readdata    = '0;

    unique case (r_state)
      StIdle: begin
        if (w_av_req || w_jtag_req) begin
          w_grant_ld  = 1'b1;
          w_state_nxt = StAcc;
        end
      end

      StAcc: begin
        // Avalon inputs are sampled here; the master holds them while stalled
        if (r_owner == OwnAv) begin
          ram_addr = av_address;
          w_acc_wr = av_write;
        end else begin
          ram_addr = MonAReg;
          w_acc_wr = w_pend_wr;
        end

        if (w_acc_wr) begin
          ram_we      = 1'b1;
          w_state_nxt = StIdle;
          if (r_owner == OwnAv) begin
            ram_be         = av_byteenable;
            ram_wdata      = av_writedata;
            av_waitrequest = 1'b0;
          end else begin
            ram_be      = {BE_W{1'b1}};
            ram_wdata   = MonDReg;
            w_jtag_done = 1'b1;
          end
        end else begin
          w_state_nxt = StRdat;
        end
      end

      StRdat: begin
        // RAM read data arrives one cycle after the address
        if (r_owner == OwnAv) begin
          av_readdata    = ram_rdata;
          av_waitrequest = 1'b0;
        end else begin
          w_jtag_done = 1'b1;
        end
        w_state_nxt = StIdle;
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  assign w_jtag_owner  = (r_state != StIdle) && (r_owner == OwnJtag);
  assign monitor_ready = !w_jtag_req && (r_state == StIdle) && !w_jtag_owner;

endmodule

// File: tb/tb_nios_upc_nios2_qsys_0_ocimem_arbiter.sv
// Self-checking bench for the OCIMEM arbiter. The bench owns a RAM model
// driven by the DUT's RAM port and a separate expected-contents array.
module tb_nios_upc_nios2_qsys_0_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [7:0]  av_address;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic        av_waitrequest;
  logic [31:0] av_readdata;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [7:0]  MonAReg;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        jtag_overrun;

  always #5 clk = ~clk;

  nios_upc_nios2_qsys_0_ocimem_arbiter #(
    .ADDR_W (8),
    .DATA_W (32)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_byteenable           (av_byteenable),
    .av_waitrequest          (av_waitrequest),
    .av_readdata             (av_readdata),
    .ram_addr                (ram_addr),
    .ram_we                  (ram_we),
    .ram_be                  (ram_be),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonAReg                 (MonAReg),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .jtag_overrun            (jtag_overrun)
  );

  // Environment RAM: byte-enabled write, registered read
  logic [31:0] mem [256];
  logic        mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
    ram_rdata <= mem[ram_addr];
  end

  // Counts RAM read cycles at address 0x50 (the address only appears in ACC)
  int rd50_cnt = 0;
  always @(negedge clk) begin
    if (reset_n && ram_addr == 8'h50 && !ram_we) rd50_cnt++;
  end

  // Reference model state
  logic [31:0] exp_mem [256];
  logic [7:0]  exp_ma;
  logic [31:0] exp_md;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // One Avalon transaction; lat is the cycle (1-based) in which waitrequest dropped
  task automatic av_txn(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] be, output int lat, output logic [31:0] rd);
    av_address    = a;
    av_read       = !wr;
    av_write      = wr;
    av_writedata  = d;
    av_byteenable = be;
    lat = 1;
    while (av_waitrequest === 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
    rd = av_readdata;
    tick();
    av_read  = 1'b0;
    av_write = 1'b0;
  endtask

  // kind 0: ocimem_a, 1: ocimem_b, 2: no_action_ocimem_a
  task automatic jtag_strobe(input int kind, input logic [7:0] a, input logic rd,
                             input logic [31:0] d);
    logic [37:0] j;
    j = 38'({$urandom(), $urandom()});
    if (kind == 0) begin
      j[33:26] = a;
      j[34]    = rd;
      take_action_ocimem_a = 1'b1;
    end else if (kind == 1) begin
      j[34:3] = d;
      take_action_ocimem_b = 1'b1;
    end else begin
      take_no_action_ocimem_a = 1'b1;
    end
    jdo = j;
    tick();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (monitor_ready !== 1'b1 && cyc < 30) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mem_clr = 1'b1;
    for (int i = 0; i < 256; i++) exp_mem[i] = 32'h0;
    exp_ma = 8'h0;
    exp_md = 32'h0;
    tick();
    tick();
    n_cmp++; if (av_waitrequest !== 1'b1) begin n_bad++; $display("FAIL reset_waitreq: got %0h want 1", av_waitrequest); end
    n_cmp++; if (monitor_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0h want 1", monitor_ready); end
    n_cmp++; if (ram_we !== 1'b0 || ram_addr !== 8'h0 || ram_be !== 4'h0 || ram_wdata !== 32'h0) begin
      n_bad++; $display("FAIL reset_ram: got we=%0h addr=%0h be=%0h wd=%0h want all 0", ram_we, ram_addr, ram_be, ram_wdata); end
    n_cmp++; if (MonAReg !== 8'h0 || MonDReg !== 32'h0) begin n_bad++; $display("FAIL reset_mon: got %0h/%0h want 0/0", MonAReg, MonDReg); end
    n_cmp++; if (jtag_overrun !== 1'b0 || av_readdata !== 32'h0) begin n_bad++; $display("FAIL reset_misc: got ovr=%0h rd=%0h want 0", jtag_overrun, av_readdata); end
    mem_clr = 1'b0;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_jtag_write();
    int n;
    int cyc;
    jtag_strobe(0, 8'h10, 1'b0, 32'h0);
    n_cmp++; if (MonAReg !== 8'h10 || monitor_ready !== 1'b1) begin n_bad++; $display("FAIL jw_load: got a=%0h rdy=%0h want 10/1", MonAReg, monitor_ready); end
    jtag_strobe(1, 8'h0, 1'b0, 32'hDEADBEEF);
    n = 0;
    while (ram_we !== 1'b1 && n < 10) begin tick(); n++; end
    n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL jw_we_cycle: got %0d want 1", n); end
    n_cmp++; if (ram_addr !== 8'h10 || ram_be !== 4'hF || ram_wdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL jw_ram: got a=%0h be=%0h d=%0h want 10/f/deadbeef", ram_addr, ram_be, ram_wdata); end
    wait_ready(cyc);
    n_cmp++; if (MonAReg !== 8'h11 || monitor_ready !== 1'b1) begin n_bad++; $display("FAIL jw_after: got a=%0h rdy=%0h want 11/1", MonAReg, monitor_ready); end
    exp_mem[8'h10] = 32'hDEADBEEF;
    exp_ma = 8'h11;
    exp_md = 32'hDEADBEEF;
  endtask

  task automatic test_avalon();
    int lat;
    logic [31:0] rd;
    av_txn(1'b1, 8'h03, 32'hFFFFFFFF, 4'hF, lat, rd);
    exp_mem[3] = merge(exp_mem[3], 32'hFFFFFFFF, 4'hF);
    av_txn(1'b1, 8'h03, 32'hA5A5A5A5, 4'h3, lat, rd);
    exp_mem[3] = merge(exp_mem[3], 32'hA5A5A5A5, 4'h3);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL av_wr_lat: got %0d want 2", lat); end
    av_txn(1'b0, 8'h03, 32'h0, 4'h0, lat, rd);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL av_rd_lat: got %0d want 3", lat); end
    n_cmp++; if (rd !== exp_mem[3]) begin n_bad++; $display("FAIL av_rd_data: got %0h want %0h", rd, exp_mem[3]); end
    av_txn(1'b1, 8'hFF, 32'h12345678, 4'hF, lat, rd);
    exp_mem[8'hFF] = 32'h12345678;
  endtask

  task automatic test_jtag_read_wrap();
    int cyc;
    jtag_strobe(0, 8'hFF, 1'b1, 32'h0);
    wait_ready(cyc);
    n_cmp++; if (cyc !== 3) begin n_bad++; $display("FAIL jr_lat: got %0d want 3", cyc); end
    n_cmp++; if (MonDReg !== exp_mem[8'hFF]) begin n_bad++; $display("FAIL jr_data: got %0h want %0h", MonDReg, exp_mem[8'hFF]); end
    n_cmp++; if (MonAReg !== 8'h00) begin n_bad++; $display("FAIL jr_wrap: got %0h want 0", MonAReg); end
    exp_ma = 8'h00;
    exp_md = exp_mem[8'hFF];
  endtask

  task automatic test_contention();
    int lat;
    int cyc;
    logic [31:0] rd;
    logic [7:0]  first;
    logic [7:0]  av_a;
    for (int r = 0; r < 2; r++) begin
      av_a = 8'h30 + 8'(r);
      if (r == 0) begin
        // JTAG-only access so the last grant is JTAG, then place MonAReg
        jtag_strobe(2, 8'h0, 1'b0, 32'h0);
        wait_ready(cyc);
        jtag_strobe(0, 8'h20, 1'b0, 32'h0);
        exp_ma = 8'h20;
`ifdef NIOS_UPC_OCIMEM_JTAG_PRIO_EN
        first = exp_ma;
`else
        first = av_a;
`endif
      end else begin
        // Avalon-only access so the last grant is Avalon
        av_txn(1'b0, 8'h01, 32'h0, 4'h0, lat, rd);
        first = exp_ma;
      end
      jtag_strobe(2, 8'h0, 1'b0, 32'h0);
      av_address = av_a;
      av_read    = 1'b1;
      tick();
      n_cmp++; if (ram_addr !== first) begin n_bad++; $display("FAIL cont%0d_first: got %0h want %0h", r, ram_addr, first); end
      lat = 0;
      while (av_waitrequest === 1'b1 && lat < 30) begin tick(); lat++; end
      rd = av_readdata;
      tick();
      av_read = 1'b0;
      n_cmp++; if (rd !== exp_mem[av_a]) begin n_bad++; $display("FAIL cont%0d_av: got %0h want %0h", r, rd, exp_mem[av_a]); end
      wait_ready(cyc);
      exp_md = exp_mem[exp_ma];
      exp_ma = exp_ma + 8'd1;
      n_cmp++; if (MonDReg !== exp_md || MonAReg !== exp_ma) begin
        n_bad++; $display("FAIL cont%0d_jtag: got %0h/%0h want %0h/%0h", r, MonAReg, MonDReg, exp_ma, exp_md); end
    end
  endtask

  task automatic test_overrun();
    int lat;
    int cyc;
    int base;
    logic [31:0] rd;
    av_txn(1'b1, 8'h50, 32'hCAFEF00D, 4'hF, lat, rd);
    exp_mem[8'h50] = 32'hCAFEF00D;
    jtag_strobe(0, 8'h50, 1'b0, 32'h0);
    base = rd50_cnt;
    jtag_strobe(2, 8'h0, 1'b0, 32'h0);
    jtag_strobe(2, 8'h0, 1'b0, 32'h0);
    jtag_strobe(0, 8'h77, 1'b0, 32'h0);
    wait_ready(cyc);
    tick();
    tick();
    tick();
    n_cmp++; if (jtag_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %0h want 1", jtag_overrun); end
    n_cmp++; if (rd50_cnt - base !== 1) begin n_bad++; $display("FAIL ovr_reads: got %0d want 1", rd50_cnt - base); end
    n_cmp++; if (MonAReg !== 8'h51 || MonDReg !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL ovr_mon: got %0h/%0h want 51/cafef00d", MonAReg, MonDReg); end
    jtag_strobe(0, 8'h60, 1'b0, 32'h0);
    n_cmp++; if (jtag_overrun !== 1'b0 || MonAReg !== 8'h60) begin
      n_bad++; $display("FAIL ovr_clear: got ovr=%0h a=%0h want 0/60", jtag_overrun, MonAReg); end
    exp_ma = 8'h60;
    exp_md = 32'hCAFEF00D;
  endtask

  task automatic test_reset_mid_read();
    jtag_strobe(0, 8'h40, 1'b1, 32'h0);
    tick();
    tick();
    // Now in RDAT of the JTAG read
    reset_n = 1'b0;
    #1;
    n_cmp++; if (MonAReg !== 8'h00 || MonDReg !== 32'h0) begin n_bad++; $display("FAIL rst_mid_mon: got %0h/%0h want 0/0", MonAReg, MonDReg); end
    n_cmp++; if (monitor_ready !== 1'b1 || av_waitrequest !== 1'b1 || ram_we !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_ctl: got rdy=%0h wr=%0h we=%0h want 1/1/0", monitor_ready, av_waitrequest, ram_we); end
    tick();
    reset_n = 1'b1;
    tick();
    exp_ma = 8'h0;
    exp_md = 32'h0;
  endtask

  task automatic test_random();
    int lat;
    int cyc;
    int op;
    logic [31:0] rd;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 4));
      a  = 8'($urandom_range(0, 255));
      d  = $urandom();
      be = 4'($urandom_range(0, 15));
      case (op)
        0: begin
          av_txn(1'b1, a, d, be, lat, rd);
          exp_mem[a] = merge(exp_mem[a], d, be);
          n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rnd%0d_avw_lat: got %0d want 2", i, lat); end
        end
        1: begin
          av_txn(1'b0, a, 32'h0, 4'h0, lat, rd);
          n_cmp++; if (lat !== 3 || rd !== exp_mem[a]) begin
            n_bad++; $display("FAIL rnd%0d_avr: got lat=%0d d=%0h want 3/%0h", i, lat, rd, exp_mem[a]); end
        end
        2: begin
          jtag_strobe(0, a, 1'b0, 32'h0);
          jtag_strobe(1, 8'h0, 1'b0, d);
          wait_ready(cyc);
          exp_mem[a] = d;
          exp_ma = a + 8'd1;
          exp_md = d;
          n_cmp++; if (cyc !== 2 || MonAReg !== exp_ma || MonDReg !== exp_md) begin
            n_bad++; $display("FAIL rnd%0d_jw: got cyc=%0d a=%0h d=%0h want 2/%0h/%0h", i, cyc, MonAReg, MonDReg, exp_ma, exp_md); end
        end
        3: begin
          jtag_strobe(0, a, 1'b1, 32'h0);
          wait_ready(cyc);
          exp_md = exp_mem[a];
          exp_ma = a + 8'd1;
          n_cmp++; if (cyc !== 3 || MonAReg !== exp_ma || MonDReg !== exp_md) begin
            n_bad++; $display("FAIL rnd%0d_jr: got cyc=%0d a=%0h d=%0h want 3/%0h/%0h", i, cyc, MonAReg, MonDReg, exp_ma, exp_md); end
        end
        default: begin
          jtag_strobe(2, 8'h0, 1'b0, 32'h0);
          wait_ready(cyc);
          exp_md = exp_mem[exp_ma];
          exp_ma = exp_ma + 8'd1;
          n_cmp++; if (cyc !== 3 || MonAReg !== exp_ma || MonDReg !== exp_md) begin
            n_bad++; $display("FAIL rnd%0d_jn: got cyc=%0d a=%0h d=%0h want 3/%0h/%0h", i, cyc, MonAReg, MonDReg, exp_ma, exp_md); end
        end
      endcase
    end
  endtask

  initial begin
    jdo                     = 38'h0;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    av_address              = 8'h0;
    av_read                 = 1'b0;
    av_write                = 1'b0;
    av_writedata            = 32'h0;
    av_byteenable           = 4'h0;
    test_reset();
    test_jtag_write();
    test_avalon();
    test_jtag_read_wrap();
    test_contention();
    test_overrun();
    test_reset_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
